fpr_wb_arbiter: RTL



---
 rtl/fpr_wb_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fpr_wb_arbiter.sv
// Writeback arbiter for the FPR single write port: grants one of NREQ requesters and
// sequences double-precision pairs as two writes. Define FPR_WB_FIXED_PRI_EN for fixed priority.
module fpr_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      dbl,
  input  logic [NREQ*AW-1:0]   wr_addr,
  input  logic [NREQ*DW-1:0]   wr_data_lo,
  input  logic [NREQ*DW-1:0]   wr_data_hi,
  output logic [NREQ-1:0]      gnt,
  output logic                 regWr,
  output logic [AW-1:0]        Rw,
  output logic [DW-1:0]        busW,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
  localparam logic [1:0] WR_HI = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          regwr_q, regwr_d;
  logic [AW-1:0] rw_q, rw_d;
  logic [DW-1:0] busw_q, busw_d;
  logic          busy_q, busy_d;
  logic          dbl_q, dbl_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [PW-1:0] base;
  logic [PW:0]   idx;
  logic          found;
  logic          window;
  logic          accept;

  logic          sel_dbl;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_lo;
  logic [DW-1:0] sel_hi;

`ifdef FPR_WB_FIXED_PRI_EN
  assign base = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) ptr_d = PW'((k + 1) % NREQ);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign base = ptr_q;
`endif

  // The next cycle is free unless the low half of a pair is being written now.
  assign window = (state_q == IDLE) || (state_q == WR_HI) ||
                  ((state_q == WR_LO) && !dbl_q);

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    if (!reset && window) begin
      for (int j = 0; j < NREQ; j++) begin
        idx = {1'b0, base} + (PW+1)'(j);
        if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
        if (!found && req[idx[PW-1:0]]) begin
          gnt[idx[PW-1:0]] = 1'b1;
          found            = 1'b1;
        end
      end
    end
  end

  assign accept = |gnt;

  always_comb begin
    sel_dbl  = 1'b0;
    sel_addr = '0;
    sel_lo   = '0;
    sel_hi   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_dbl  = dbl[k];
        sel_addr = wr_addr[k*AW +: AW];
        sel_lo   = wr_data_lo[k*DW +: DW];
        sel_hi   = wr_data_hi[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    regwr_d = regwr_q;
    rw_d    = rw_q;
    busw_d  = busw_q;
    dbl_d   = dbl_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    if (accept) begin
      state_d = WR_LO;
      regwr_d = 1'b1;
      busw_d  = sel_lo;
      rw_d    = sel_dbl ? {sel_addr[AW-1:1], 1'b0} : sel_addr;
      dbl_d   = sel_dbl;
      hi_d    = sel_hi;
      addr_d  = sel_addr;
    end else begin
      case (state_q)
        WR_LO: begin
          if (dbl_q) begin
            state_d = WR_HI;
            regwr_d = 1'b1;
            rw_d    = {addr_q[AW-1:1], 1'b1};
            busw_d  = hi_q;
            dbl_d   = 1'b0;
          end else begin
            state_d = IDLE;
            regwr_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          regwr_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      regwr_q <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
      busy_q  <= 1'b0;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      regwr_q <= regwr_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
      busy_q  <= busy_d;
      dbl_q   <= dbl_d;
    end
  end

  // Pair payload is only consumed after dbl_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    hi_q   <= hi_d;
    addr_q <= addr_d;
  end

  assign regWr = regwr_q;
  assign Rw    = rw_q;
  assign busW  = busw_q;
  assign busy  = busy_q;

endmodule
